// File: rtl/wb_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_master_arbiter
// Purpose  : Two-master Wishbone arbiter, round-robin fairness, hang watchdog.
// Revision : 1.0
// ============================================================================
module wb_rr_master_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter int          TO_W     = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        err_o,
    output logic [31:0] err_adr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;       // index of the master served most recently
    logic            w_last_nxt;
    logic [TO_W-1:0] r_cnt;
    logic            r_err;
    logic [31:0]     r_err_adr;

    logic            w_own0;
    logic            w_own1;
    logic            w_own_stb;
    logic            w_timeout;

    assign w_own0    = (r_state == S_GNT0);
    assign w_own1    = (r_state == S_GNT1);
    assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
    // A real ack on the last allowed cycle takes priority over the watchdog.
    assign w_timeout = w_own_stb & ~s_ack_i & (r_cnt == c_TO_LAST);

    assign s_adr_o   = w_own1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o   = w_own1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o   = w_own1 ? m1_sel_i : m0_sel_i;
    assign s_we_o    = (w_own0 & m0_we_i) | (w_own1 & m1_we_i);
    assign s_stb_o   = w_own_stb & ~w_timeout;

    assign m0_ack_o  = w_own0 & (s_ack_i | w_timeout);
    assign m1_ack_o  = w_own1 & (s_ack_i | w_timeout);
    assign m0_dat_o  = (w_own0 & w_timeout) ? ERR_DATA : s_dat_i;
    assign m1_dat_o  = (w_own1 & w_timeout) ? ERR_DATA : s_dat_i;

    assign gnt_o     = {w_own1, w_own0};
    assign err_o     = r_err;
    assign err_adr_o = r_err_adr;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (m0_stb_i && (!m1_stb_i || r_last)) begin
                    w_state_nxt = S_GNT0;
                end else if (m1_stb_i) begin
                    w_state_nxt = S_GNT1;
                end
            end
            S_GNT0: begin
                if (s_ack_i || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b0;
                end else if (!m0_stb_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GNT1: begin
                if (s_ack_i || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b1;
                end else if (!m1_stb_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_err_adr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            // Every grant is preceded by an IDLE cycle, so the count starts at 0.
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (!s_ack_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_err <= w_timeout;
            if (w_timeout) begin
                r_err_adr <= s_adr_o;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_master_arbiter
// Purpose  : Self-checking bench: transaction table, scoreboard, corner cases.
// Revision : 1.0
// ============================================================================
module tb_wb_rr_master_arbiter;

    localparam int c_TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_stb_i, m1_we_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i, err_adr_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_ack_i, err_o;
    logic [1:0]  gnt_o;

    wb_rr_master_arbiter #(.TIMEOUT(c_TO), .TO_W(8), .ERR_DATA(32'hDEAD_BEEF)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .err_o(err_o), .err_adr_o(err_adr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; } req_t;
    typedef struct { logic [31:0] dat; logic [31:0] adr; bit to; } exp_t;
    typedef struct {
        int n0; int n1; int delay; logic [31:0] sdat;
        logic [31:0] adr0; logic [31:0] adr1; logic [31:0] dat1; logic we1;
    } vec_t;

    req_t mq0[$], mq1[$];
    exp_t sb0[$], sb1[$];
    int   n_tests = 0, n_fail = 0;
    int   slave_delay = 0, wcnt = 0, gcyc = 0;
    logic [31:0] slave_data = '0;
    bit   busy0 = 0, busy1 = 0, ack_seen0 = 0, ack_seen1 = 0, rq0 = 0, rq1 = 0;
    bit   chk_en = 0, m_last = 1, exp_err = 0;
    logic [31:0] exp_eadr = '0;
    logic [1:0]  p_gnt = '0, exp_g;
    bit   p_s0 = 0, p_s1 = 0, p_rst = 1, p_ack = 0;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input req_t r);
        exp_t e;
        e.to  = (slave_delay < 0) || (slave_delay >= c_TO);
        e.dat = e.to ? 32'hDEAD_BEEF : slave_data;
        e.adr = r.adr;
        return e;
    endfunction

    // Masters: hold stb until ack, then present the next queued request.
    always begin
        req_t r;
        @(posedge clk_i);
        rq0 = rst_i;
        #2;
        if (rq0) begin busy0 = 0; m0_stb_i = 0; sb0.delete(); end
        else if (busy0 && ack_seen0) begin busy0 = 0; m0_stb_i = 0; end
        if (!rq0 && !busy0 && mq0.size() > 0) begin
            r = mq0.pop_front();
            m0_adr_i = r.adr; m0_dat_i = r.dat; m0_we_i = r.we; m0_sel_i = 4'hF;
            m0_stb_i = 1; busy0 = 1;
            sb0.push_back(mk_exp(r));
        end
    end

    always begin
        req_t r;
        @(posedge clk_i);
        rq1 = rst_i;
        #2;
        if (rq1) begin busy1 = 0; m1_stb_i = 0; sb1.delete(); end
        else if (busy1 && ack_seen1) begin busy1 = 0; m1_stb_i = 0; end
        if (!rq1 && !busy1 && mq1.size() > 0) begin
            r = mq1.pop_front();
            m1_adr_i = r.adr; m1_dat_i = r.dat; m1_we_i = r.we; m1_sel_i = 4'hF;
            m1_stb_i = 1; busy1 = 1;
            sb1.push_back(mk_exp(r));
        end
    end

    // Slave: ack on grant cycle slave_delay+1; negative delay never acks.
    always begin
        @(posedge clk_i);
        #3;
        s_dat_i = slave_data;
        if (gnt_o != 2'b00) begin
            s_ack_i = (slave_delay >= 0) && (wcnt == slave_delay);
            wcnt++;
        end else begin
            s_ack_i = 0;
            wcnt = 0;
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        ack_seen0 = m0_ack_o;
        ack_seen1 = m1_ack_o;
        if (chk_en) begin
            if (p_rst) exp_g = 2'b00;
            else if (p_gnt == 2'b00)
                exp_g = (p_s0 && (!p_s1 || m_last)) ? 2'b01 : (p_s1 ? 2'b10 : 2'b00);
            else exp_g = p_ack ? 2'b00 : p_gnt;
            check("gnt", gnt_o, exp_g);
            gcyc = (gnt_o != 2'b00) ? gcyc + 1 : 0;
            check("err_o", err_o, exp_err);
            if (exp_err) check("err_adr", err_adr_o, exp_eadr);
            exp_err = 0;
            if (gnt_o == 2'b01)
                check("mirror m0", {s_adr_o, s_dat_o, s_sel_o, s_we_o},
                      {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i});
            else if (gnt_o == 2'b10)
                check("mirror m1", {s_adr_o, s_dat_o, s_sel_o, s_we_o},
                      {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i});
            else
                check("idle stb/we", {s_stb_o, s_we_o}, 2'b00);
            if (m0_ack_o) begin
                check("m0 ack owner", {m1_ack_o, gnt_o}, 3'b001);
                if (sb0.size() == 0) check("unexpected m0 ack", 1, 0);
                else begin
                    e = sb0.pop_front();
                    check("m0 data", m0_dat_o, e.dat);
                    if (e.to) begin
                        check("m0 timeout cycle", gcyc, c_TO);
                        exp_err = 1; exp_eadr = e.adr;
                    end
                end
            end
            if (m1_ack_o) begin
                check("m1 ack owner", {m0_ack_o, gnt_o}, 3'b010);
                if (sb1.size() == 0) check("unexpected m1 ack", 1, 0);
                else begin
                    e = sb1.pop_front();
                    check("m1 data", m1_dat_o, e.dat);
                    if (e.to) begin
                        check("m1 timeout cycle", gcyc, c_TO);
                        exp_err = 1; exp_eadr = e.adr;
                    end
                end
            end
            if (rst_i) m_last = 1;
            else if (m0_ack_o) m_last = 0;
            else if (m1_ack_o) m_last = 1;
        end
        p_gnt = gnt_o; p_s0 = m0_stb_i; p_s1 = m1_stb_i; p_rst = rst_i;
        p_ack = m0_ack_o | m1_ack_o;
    end

    task automatic pulse_reset(input int delay, input logic [31:0] sdat);
        @(posedge clk_i); #1;
        rst_i = 1; slave_delay = delay; slave_data = sdat;
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (k < 300 && (mq0.size() != 0 || mq1.size() != 0 || busy0 || busy1 ||
                           gnt_o != 2'b00)) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 300) check({nm, " drain timeout"}, 1, 0);
        repeat (3) @(negedge clk_i);
        check({nm, " scoreboard empty"}, sb0.size() + sb1.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        pulse_reset(v.delay, v.sdat);
        for (int i = 0; i < v.n0; i++)
            mq0.push_back('{adr: v.adr0 + 32'(i * 4), dat: 32'(i), we: 1'b0});
        for (int i = 0; i < v.n1; i++)
            mq1.push_back('{adr: v.adr1 + 32'(i * 4), dat: v.dat1, we: v.we1});
        drain($sformatf("vec%0d", idx));
    endtask

    vec_t vecs[6];

    initial begin
        int k;
        vecs[0] = '{1, 0, 2,  32'h1234_5678, 32'h1000_0000, 32'h0,         32'h0,   1'b0};
        vecs[1] = '{2, 2, 1,  32'hA5A5_0001, 32'h3000_0000, 32'h4000_0000, 32'h0,   1'b0};
        vecs[2] = '{0, 1, 0,  32'h0000_0011, 32'h0,         32'hFFFF_FF00, 32'hAA,  1'b1};
        vecs[3] = '{1, 0, -1, 32'h0000_0000, 32'h2000_0004, 32'h0,         32'h0,   1'b0};
        vecs[4] = '{1, 0, 7,  32'h0000_0055, 32'h2000_0008, 32'h0,         32'h0,   1'b0};
        vecs[5] = '{3, 3, 0,  32'hCAFE_F00D, 32'h5000_0000, 32'h6000_0000, 32'h77,  1'b1};

        rst_i = 1; s_ack_i = 0; s_dat_i = '0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_stb_i = 0;
        repeat (3) @(negedge clk_i);
        check("reset gnt/err", {gnt_o, err_o}, 3'b000);
        check("reset err_adr", err_adr_o, 32'h0);
        check("reset stb/we/acks", {s_stb_o, s_we_o, m0_ack_o, m1_ack_o}, 4'b0000);
        chk_en = 1;
        @(posedge clk_i); #1;
        rst_i = 0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while m1 owns a transfer that the slave never acks.
        pulse_reset(-1, 32'h0);
        mq1.push_back('{adr: 32'h7000_0000, dat: 32'h1, we: 1'b1});
        k = 0;
        while (k < 50 && gnt_o != 2'b10) begin @(negedge clk_i); k++; end
        check("rst seq: m1 granted", gnt_o, 2'b10);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1;
        @(negedge clk_i);
        check("rst seq: still GNT1 before edge", gnt_o, 2'b10);
        @(negedge clk_i);
        check("rst seq: idle after reset", {gnt_o, s_stb_o, m1_ack_o, err_o}, 5'b0);
        @(posedge clk_i); #1;
        rst_i = 0; slave_delay = 1; slave_data = 32'h0BAD_CAFE;
        @(posedge clk_i); #1;
        mq0.push_back('{adr: 32'h8000_0000, dat: 32'h2, we: 1'b0});
        mq1.push_back('{adr: 32'h9000_0000, dat: 32'h3, we: 1'b0});
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst seq: m0 wins after reset", gnt_o, 2'b01);
        drain("rst seq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
